// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: Tuse/Tnew encodings,
// multiply/divide busy FSM states and default unit latencies.
package hazard_pkg;

  // A Tuse of 3 marks an operand the D instruction never reads.
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_ZERO = 2'd0;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MdIdle = 1'b0,
    MdBusy = 1'b1
  } md_state_e;

  // One producer/consumer pair: stall when D needs the value before it can be forwarded.
  function automatic logic raw_hit(logic [4:0] src, logic [1:0] tuse,
                                   logic [4:0] wa, logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) &&
           (tnew != TNEW_ZERO) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy window tracker: IDLE/BUSY FSM with a countdown loaded on issue.
// md_busy rises the cycle after md_start and stays high for exactly the unit latency.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MdIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      MdIdle: begin
        if (md_start) begin
          count_d = md_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          state_d = MdBusy;
        end
      end
      MdBusy: begin
        // A new md_start here is dropped; the D-stage stall keeps it from happening.
        if (count_q == CntW'(1)) begin
          count_d = '0;
          state_d = MdIdle;
        end else begin
          count_d = count_q - CntW'(1);
        end
      end
      default: begin
        state_d = MdIdle;
        count_d = '0;
      end
    endcase
  end

  assign md_busy = (state_q == MdBusy);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS stall controller: Tuse/Tnew RAW comparators plus the md busy window.
// Optional STALL_CNT_EN macro adds a saturating stall_cycles counter port.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_md_use,
  input  logic [4:0]  e_wa,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_flush,
  output logic        md_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic raw_stall;
  logic md_stall;
  logic stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy)
  );

  always_comb begin
    raw_stall = raw_hit(d_rs_addr, d_tuse_rs, e_wa, e_tnew) |
                raw_hit(d_rs_addr, d_tuse_rs, m_wa, m_tnew) |
                raw_hit(d_rt_addr, d_tuse_rt, e_wa, e_tnew) |
                raw_hit(d_rt_addr, d_tuse_rt, m_wa, m_tnew);
    md_stall  = d_md_use & (md_busy | md_start);
    // Reset forces the pipeline to advance regardless of hazard inputs.
    stall     = (raw_stall | md_stall) & ~reset;
    pc_en     = ~stall;
    d_en      = ~stall;
    e_flush   = stall;
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected {pc_en,d_en,e_flush,md_busy} queued per cycle
// and compared at the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs_addr;
  logic [4:0]  d_rt_addr;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_md_use;
  logic [4:0]  e_wa;
  logic [4:0]  m_wa;
  logic [1:0]  e_tnew;
  logic [1:0]  m_tnew;
  logic        md_start;
  logic        md_is_div;
  logic        pc_en;
  logic        d_en;
  logic        e_flush;
  logic        md_busy;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_cmp;
  int        n_err;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .d_rs_addr    (d_rs_addr),
    .d_rt_addr    (d_rt_addr),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_md_use     (d_md_use),
    .e_wa         (e_wa),
    .m_wa         (m_wa),
    .e_tnew       (e_tnew),
    .m_tnew       (m_tnew),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .pc_en        (pc_en),
    .d_en         (d_en),
    .e_flush      (e_flush),
    .md_busy      (md_busy)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    d_rs_addr = 5'd0;
    d_rt_addr = 5'd0;
    d_tuse_rs = 2'd3;
    d_tuse_rt = 2'd3;
    d_md_use  = 1'b0;
    e_wa      = 5'd0;
    m_wa      = 5'd0;
    e_tnew    = 2'd0;
    m_tnew    = 2'd0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
  endtask

  // Inputs are set by the caller just after a rising edge; this checks the cycle
  // at the falling edge and then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] exp);
    sb_entry_t e;
    logic [3:0] obs;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    e   = sb_q.pop_front();
    obs = {pc_en, d_en, e_flush, md_busy};
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed {pc_en,d_en,e_flush,md_busy}=%b expected %b", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    quiet();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset overrides a RAW hazard and a pending md issue.
    d_rs_addr = 5'd1; d_tuse_rs = 2'd1; e_wa = 5'd1; e_tnew = 2'd2;
    d_md_use  = 1'b1; md_start  = 1'b1;
    cyc("rst_force", 4'b1100);

    reset = 1'b0;
    quiet();
    cyc("rst_idle", 4'b1100);

    // $0 never stalls.
    d_rs_addr = 5'd0; d_tuse_rs = 2'd0; e_wa = 5'd0; e_tnew = 2'd2;
    cyc("zero_reg", 4'b1100);
    // Tuse 3 (unused operand) never stalls.
    quiet();
    d_rs_addr = 5'd7; d_tuse_rs = 2'd3; e_wa = 5'd7; e_tnew = 2'd2;
    cyc("tuse_none", 4'b1100);
    // Tuse equal to Tnew forwards in time.
    d_tuse_rs = 2'd2;
    cyc("tuse_eq", 4'b1100);

    // mult issue with mflo in D: 1 + 5 stall cycles.
    quiet();
    md_start = 1'b1; md_is_div = 1'b0; d_md_use = 1'b1;
    cyc("mult_c1", 4'b0010);
    md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Overlap a RAW hazard on one busy cycle: still a single stall.
      if (i == 1) begin
        d_rt_addr = 5'd9; d_tuse_rt = 2'd0; m_wa = 5'd9; m_tnew = 2'd1;
      end else begin
        d_rt_addr = 5'd0; d_tuse_rt = 2'd3; m_wa = 5'd0; m_tnew = 2'd0;
      end
      cyc($sformatf("mult_busy%0d", i + 2), 4'b0011);
    end
    quiet();
    d_md_use = 1'b1;
    cyc("mult_c7", 4'b1100);

    // lw in E, dependent add in D: one stall, then forwarded from M.
    quiet();
    d_rs_addr = 5'd1; d_tuse_rs = 2'd1; e_wa = 5'd1; e_tnew = 2'd2;
    cyc("lw_e", 4'b0010);
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd1; m_tnew = 2'd1;
    cyc("lw_m", 4'b1100);
`ifdef STALL_CNT_EN
    n_cmp++;
    assert (stall_cycles === 32'd7) else begin
      n_err++;
      $error("FAIL stall_cnt: observed %0d expected %0d", stall_cycles, 7);
    end
`endif

    // rt hazard against M.
    quiet();
    d_rt_addr = 5'd5; d_tuse_rt = 2'd0; m_wa = 5'd5; m_tnew = 2'd1;
    cyc("rt_m", 4'b0010);

    // div followed by non-md instructions: no stall, busy exactly 10 cycles.
    quiet();
    md_start = 1'b1; md_is_div = 1'b1;
    cyc("div_issue", 4'b1100);
    for (int i = 0; i < 10; i++) begin
      quiet();
      // An issue while busy must neither reload nor extend the window.
      if (i == 2) begin
        md_start = 1'b1; md_is_div = 1'b0;
      end
      cyc($sformatf("div_busy%0d", i + 1), 4'b1101);
    end
    quiet();
    cyc("div_done", 4'b1100);

    // Reset in busy cycle 4 abandons the divide.
    md_start = 1'b1; md_is_div = 1'b1;
    cyc("div2_issue", 4'b1100);
    quiet();
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("div2_busy%0d", i + 1), 4'b1101);
    end
    reset = 1'b1; d_md_use = 1'b1;
    cyc("div2_rst", 4'b1101);
    reset = 1'b0;
    cyc("mfhi_after_rst", 4'b1100);
`ifdef STALL_CNT_EN
    n_cmp++;
    assert (stall_cycles === 32'd0) else begin
      n_err++;
      $error("FAIL stall_cnt_rst: observed %0d expected %0d", stall_cycles, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall controller for the five-stage MIPS core. It compares the D-stage operand needs (Tuse) against the E/M-stage producer timing (Tnew), and tracks the multiply/divide unit's busy window with an internal countdown. It drives the PC register enable, the IF/ID register enable and the ID/EX flush, so that a stalled instruction holds in D while a bubble enters E.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles after a mult/multu issue.
- DIV_CYCLES, default 10: busy cycles after a div/divu issue.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- d_rs_addr, d_rt_addr  in  5 each  D-stage source register numbers.
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs rs/rt; 3 = operand not used.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa, m_wa  in  5 each  destination register of the E/M instruction; 0 = no write.
- e_tnew, m_tnew  in  2 each  cycles until the E/M result is forwardable.
- md_start  in  1  E holds mult/multu/div/divu this cycle.
- md_is_div  in  1  qualifies md_start; 1 = divide.
- pc_en  out  1  PC register enable.
- d_en  out  1  IF/ID register enable.
- e_flush  out  1  clear the ID/EX register to a nop.
- md_busy  out  1  multiply/divide unit busy.
- stall_cycles  out  32  present only under STALL_CNT_EN.

## Operation
- Data stall, raw_stall:
  - An rs term fires when rs != 0, rs == e_wa and d_tuse_rs < e_tnew.
  - A second rs term fires when rs != 0, rs == m_wa and d_tuse_rs < m_tnew.
  - rt has the same two terms. raw_stall is the OR of all four.
- MD stall, md_stall = d_md_use & (md_busy | md_start).
- stall = raw_stall | md_stall.
- Outputs: pc_en = !stall, d_en = !stall, e_flush = stall. These are combinational, with no registered delay.
- MD counter FSM, states IDLE and BUSY:
  - IDLE with md_start: load count = md_is_div ? DIV_CYCLES : MULT_CYCLES, then go to BUSY.
  - BUSY: decrement count each cycle. When count == 1, go to IDLE with count = 0.
  - md_start while BUSY is ignored. It is not reloaded and not queued; the stall logic prevents it.
  - md_busy = (state == BUSY).
- Count register width is the clog2 of the larger parameter plus 1. Parameters must be ≥ 1.

## Timing
- Reset: state IDLE, count 0, md_busy 0, stall_cycles 0.
- While reset is high, pc_en = 1, d_en = 1, e_flush = 0, regardless of other inputs.
- md_busy rises the cycle after md_start is sampled and stays high exactly N cycles (N = 5 or 10).
- A D-stage md instruction directly behind a mult is stalled 1 + N cycles: the md_start cycle plus the busy window.
- Reset mid-BUSY: IDLE on the next edge; the busy window is abandoned.
- Simultaneous raw_stall and md_stall: a single stall, same outputs.
- Tuse 3 never stalls, because Tnew ≤ 2.

## Configuration
- STALL_CNT_EN defined: the stall_cycles port exists.
  - It increments on every clock edge where stall = 1 and reset = 0.
  - It saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: the port and counter are absent; stall behaviour is unchanged.

## Structure
- Shared package hazard_pkg holds:
  - Tuse/Tnew constants TUSE_NONE = 2'd3 and TNEW_ZERO = 2'd0.
  - The MD FSM state encoding.
  - Default MULT_CYCLES/DIV_CYCLES values.
- Sub-module md_busy_counter holds the IDLE/BUSY FSM and countdown. Inputs: clk, reset, md_start, md_is_div. Output: md_busy.
- The top module holds the comparators, output logic and the optional stall counter.

## Test plan
- lw $1 in E (e_wa=1, e_tnew=2), D add using rs=1 with tuse 1 -> stall for 1 cycle: pc_en=0, d_en=0, e_flush=1. Next cycle m_tnew=1 ≥ tuse, so no stall.
- rs = 0 in D with e_wa = 0 and e_tnew = 2 -> no stall (the $0 exemption).
- mult issued (md_start=1, md_is_div=0) with mflo in D -> stall 6 consecutive cycles; md_busy high for cycles 2–6; pc_en returns to 1 in cycle 7.
- div issued, then D nop (d_md_use=0) -> no stall; md_busy high exactly 10 cycles.
- div issued, reset asserted in busy cycle 4 -> md_busy=0 after the edge; mfhi in D does not stall the following cycle.
- With STALL_CNT_EN: the mult/mflo case followed by the lw hazard -> stall_cycles = 7.
